// File: rtl/generic_rom_arbiter.sv
// Round-robin arbiter that shares one registered-read ROM among N_REQ requesters.
// A requester may hold the grant for a bounded burst; responses come back one cycle later, tagged one-hot.
module generic_rom_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int MAX_BURST     = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [N_REQ-1:0]                 i_req_valid,
  input  logic [N_REQ-1:0]                 i_req_lock,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0]   i_req_addr,
  output logic [N_REQ-1:0]                 o_req_ready,
  output logic [N_REQ-1:0]                 o_rsp_valid,
  output logic [DATA_WIDTH-1:0]            o_rsp_data,
  output logic [ADDRESS_WIDTH-1:0]         o_rom_address,
  input  logic [DATA_WIDTH-1:0]            i_rom_read_data
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [PW-1:0] LAST_ID    = PW'(N_REQ - 1);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          owner_v_q, owner_v_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rsp_v_q, rsp_v_d;
  logic [PW-1:0] rsp_id_q, rsp_id_d;

  logic          gnt_v;
  logic [PW-1:0] gnt_id;

  logic [PW-1:0]            cand_id  [N_REQ];
  logic [ADDRESS_WIDTH-1:0] req_addr [N_REQ];

  // cand_id[i] is the requester visited i-th in the rotation starting at rr_ptr.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    logic [PW:0] sum;
    assign sum           = {1'b0, rr_ptr_q} + (PW+1)'(gi);
    assign cand_id[gi]   = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : sum[PW-1:0];
    assign req_addr[gi]  = i_req_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign o_req_ready[gi] = gnt_v && (gnt_id == PW'(gi));
    assign o_rsp_valid[gi] = !i_rst && rsp_v_q && (rsp_id_q == PW'(gi));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q    <= '0;
      owner_v_q   <= 1'b0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rsp_v_q     <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      owner_v_q   <= owner_v_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rsp_v_q     <= rsp_v_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Reverse scan so the candidate closest to rr_ptr wins.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    if (!i_rst) begin
      if (owner_v_q && i_req_valid[owner_q]) begin
        gnt_v  = 1'b1;
        gnt_id = owner_q;
      end else begin
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (i_req_valid[cand_id[i]]) begin
            gnt_v  = 1'b1;
            gnt_id = cand_id[i];
          end
        end
      end
    end
  end

  // Any cycle that does not extend a lock (including idle cycles) drops ownership.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    owner_v_d   = 1'b0;
    owner_d     = owner_q;
    burst_cnt_d = '0;
    rsp_v_d     = gnt_v;
    rsp_id_d    = rsp_id_q;
    if (gnt_v) begin
      rr_ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
      rsp_id_d = gnt_id;
      if (i_req_lock[gnt_id] && (burst_cnt_q < BURST_LAST)) begin
        owner_v_d   = 1'b1;
        owner_d     = gnt_id;
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end
  end

  assign o_rom_address = gnt_v ? req_addr[gnt_id] : '0;
  assign o_rsp_data    = i_rom_read_data;

endmodule

// File: tb/tb_generic_rom_arbiter.sv
// Bench for generic_rom_arbiter: directed vector table, a locked-burst rotation sequence,
// and randomized traffic checked against a queue-free arithmetic reference model.
module tb_generic_rom_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]    ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(logic [AW-1:0] a);
    if (a == 10'h005) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Behavioural ROM with one-cycle registered read.
  always @(posedge clk) rom_q <= rom_word(rom_addr);

  generic_rom_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req_valid(valid),
    .i_req_lock(lock),
    .i_req_addr(addr),
    .o_req_ready(ready),
    .o_rsp_valid(rsp_valid),
    .o_rsp_data(rsp_data),
    .o_rom_address(rom_addr),
    .i_rom_read_data(rom_q)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            rst;
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*AW-1:0] a;
    logic [N-1:0]    e_rdy;
    logic [AW-1:0]   e_addr;
    logic [N-1:0]    e_rsp;
    logic [AW-1:0]   e_raddr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [N*AW-1:0] pk(int a0, int a1, int a2, int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic vec_t mk(logic r, logic [N-1:0] v, logic [N-1:0] l, logic [N*AW-1:0] a,
                              logic [N-1:0] er, int ea, logic [N-1:0] es, int esa);
    vec_t t;
    t.rst = r; t.v = v; t.l = l; t.a = a;
    t.e_rdy = er; t.e_addr = AW'(ea); t.e_rsp = es; t.e_raddr = AW'(esa);
    return t;
  endfunction

  // Reference model state
  int            m_ptr, m_owner, m_burst, m_rsp_id, g;
  logic          m_rsp_v, r;
  logic [AW-1:0] m_rsp_addr, e_a;
  logic [N-1:0]  e_rdy, e_rsp, lock_r, one;
  logic          req_v [N];
  logic [AW-1:0] req_a [N];
  int            wait_cnt [N];

  initial begin
    logic [N*AW-1:0] a_a, a_b, a_c, a_d, a_e, a_f;
    a_a = pk(0, 0, 5, 0);
    a_b = pk(0, 1, 2, 3);
    a_c = pk(0, 'h11, 0, 'h33);
    a_d = pk('h20, 0, 'h22, 0);
    a_e = pk('h40, 'h41, 0, 0);
    a_f = pk(7, 8, 0, 'h3FF);
    one = N'(1);

    // single request
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, a_a, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0100, 4'b0000, a_a, 4'b0100, 5,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_a, 4'b0000, 0,      4'b0100, 5));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_a, 4'b0000, 0,      4'b0000, 0));
    // round robin, all valid
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, a_b, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, a_b, 4'b0001, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, a_b, 4'b0010, 1,      4'b0001, 0));
    tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, a_b, 4'b0100, 2,      4'b0010, 1));
    tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, a_b, 4'b1000, 3,      4'b0100, 2));
    tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, a_b, 4'b0001, 0,      4'b1000, 3));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_b, 4'b0000, 0,      4'b0001, 0));
    // burst lock: 1,1,1,1,3,1
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, a_c, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b1010, 4'b0010, a_c, 4'b0010, 'h11,   4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b1010, 4'b0010, a_c, 4'b0010, 'h11,   4'b0010, 'h11));
    tbl.push_back(mk(1'b0, 4'b1010, 4'b0010, a_c, 4'b0010, 'h11,   4'b0010, 'h11));
    tbl.push_back(mk(1'b0, 4'b1010, 4'b0010, a_c, 4'b0010, 'h11,   4'b0010, 'h11));
    tbl.push_back(mk(1'b0, 4'b1010, 4'b0010, a_c, 4'b1000, 'h33,   4'b0010, 'h11));
    tbl.push_back(mk(1'b0, 4'b1010, 4'b0010, a_c, 4'b0010, 'h11,   4'b1000, 'h33));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_c, 4'b0000, 0,      4'b0010, 'h11));
    // lock released early by dropping valid
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, a_d, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0101, 4'b0001, a_d, 4'b0001, 'h20,   4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0101, 4'b0001, a_d, 4'b0001, 'h20,   4'b0001, 'h20));
    tbl.push_back(mk(1'b0, 4'b0100, 4'b0001, a_d, 4'b0100, 'h22,   4'b0001, 'h20));
    tbl.push_back(mk(1'b0, 4'b0101, 4'b0000, a_d, 4'b0001, 'h20,   4'b0100, 'h22));
    tbl.push_back(mk(1'b0, 4'b0101, 4'b0000, a_d, 4'b0100, 'h22,   4'b0001, 'h20));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_d, 4'b0000, 0,      4'b0100, 'h22));
    // reset mid-operation drops the in-flight response
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, a_e, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, a_e, 4'b0010, 'h41,   4'b0000, 0));
    tbl.push_back(mk(1'b1, 4'b0010, 4'b0000, a_e, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0011, 4'b0000, a_e, 4'b0001, 'h40,   4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, a_e, 4'b0010, 'h41,   4'b0001, 'h40));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_e, 4'b0000, 0,      4'b0010, 'h41));
    // idle cycles and pointer wrap from the last requester
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, a_f, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b1000, 4'b0000, a_f, 4'b1000, 'h3FF,  4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_f, 4'b0000, 0,      4'b1000, 'h3FF));
    tbl.push_back(mk(1'b0, 4'b1000, 4'b0000, a_f, 4'b1000, 'h3FF,  4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_f, 4'b0000, 0,      4'b1000, 'h3FF));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_f, 4'b0000, 0,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0011, 4'b0000, a_f, 4'b0001, 7,      4'b0000, 0));
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, a_f, 4'b0010, 8,      4'b0001, 7));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, a_f, 4'b0000, 0,      4'b0010, 8));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; valid = tbl[i].v; lock = tbl[i].l; addr = tbl[i].a;
      #3;
      chk($sformatf("vec%0d ready", i), 64'(ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d rom_addr", i), 64'(rom_addr), 64'(tbl[i].e_addr));
      chk($sformatf("vec%0d rsp_valid", i), 64'(rsp_valid), 64'(tbl[i].e_rsp));
      if (tbl[i].e_rsp != '0)
        chk($sformatf("vec%0d rsp_data", i), 64'(rsp_data), 64'(rom_word(tbl[i].e_raddr)));
      $display("vec %0d: rst=%b valid=%b ready=%b addr=%0h rsp_valid=%b", i, rst, valid, ready, rom_addr, rsp_valid);
      @(posedge clk); #1;
    end

    // Everyone valid and locking: each requester keeps the ROM for exactly MB grants.
    rst = 1'b1; valid = '0; lock = '0;
    @(posedge clk); #1;
    rst = 1'b0; valid = '1; lock = '1; addr = a_b;
    for (int c = 0; c < 4 * MB; c++) begin
      #3;
      chk($sformatf("burst c%0d ready", c), 64'(ready), 64'(one << (c / MB)));
      if (c > 0) begin
        chk($sformatf("burst c%0d rsp_valid", c), 64'(rsp_valid), 64'(one << ((c - 1) / MB)));
        chk($sformatf("burst c%0d rsp_data", c), 64'(rsp_data), 64'(rom_word(AW'((c - 1) / MB))));
      end
      $display("burst %0d: ready=%b rsp_valid=%b", c, ready, rsp_valid);
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model.
    rst = 1'b1; valid = '0; lock = '0;
    @(posedge clk); #1;
    m_ptr = 0; m_owner = -1; m_burst = 0; m_rsp_v = 1'b0; m_rsp_id = 0; m_rsp_addr = '0;
    for (int k = 0; k < N; k++) begin req_v[k] = 1'b0; req_a[k] = '0; wait_cnt[k] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < N; k++) begin
        if (!req_v[k]) begin
          req_v[k] = ($urandom_range(0, 99) < 55);
          req_a[k] = AW'($urandom);
        end
      end
      lock_r = N'($urandom);
      rst = r; lock = lock_r;
      for (int k = 0; k < N; k++) begin
        valid[k] = req_v[k];
        addr[k*AW +: AW] = req_a[k];
      end

      g = -1;
      if (!r) begin
        if (m_owner >= 0 && req_v[m_owner]) g = m_owner;
        else
          for (int i = 0; i < N; i++)
            if (g < 0 && req_v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      end
      e_rdy = (g >= 0) ? (one << g) : '0;
      e_a   = (g >= 0) ? req_a[g] : '0;
      e_rsp = (!r && m_rsp_v) ? (one << m_rsp_id) : '0;

      #3;
      chk($sformatf("rand%0d ready", cyc), 64'(ready), 64'(e_rdy));
      chk($sformatf("rand%0d rom_addr", cyc), 64'(rom_addr), 64'(e_a));
      chk($sformatf("rand%0d rsp_valid", cyc), 64'(rsp_valid), 64'(e_rsp));
      if (e_rsp != '0)
        chk($sformatf("rand%0d rsp_data", cyc), 64'(rsp_data), 64'(rom_word(m_rsp_addr)));
      if (g >= 0)
        chk($sformatf("rand%0d wait_bound req%0d waited %0d", cyc, g, wait_cnt[g]),
            64'(wait_cnt[g] <= (N - 1) * MB), 64'(1));
      $display("rand %0d: rst=%b valid=%b lock=%b ready=%b rsp_valid=%b", cyc, rst, valid, lock, ready, rsp_valid);

      if (r) begin
        m_ptr = 0; m_owner = -1; m_burst = 0; m_rsp_v = 1'b0;
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
      end else begin
        for (int k = 0; k < N; k++) if (req_v[k] && k != g) wait_cnt[k]++;
        if (g >= 0) begin
          m_ptr = (g + 1) % N;
          if (lock_r[g] && m_burst < MB - 1) begin
            m_owner = g; m_burst++;
          end else begin
            m_owner = -1; m_burst = 0;
          end
          m_rsp_v = 1'b1; m_rsp_id = g; m_rsp_addr = req_a[g];
          req_v[g] = 1'b0; wait_cnt[g] = 0;
        end else begin
          m_rsp_v = 1'b0; m_owner = -1; m_burst = 0;
        end
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
